philv_trace_buffer: RTL and testbench

- Synthesizable, parametrised per-cycle execution tracer for the Philosophy V core.
- Runs a capture window of a programmable number of cycles and records {cycle, controller state, PC, instruction, probe register} snapshots into an on-chip buffer.
- Supports an optional PC-match trigger with pre/post-trigger capture.
- Streams the captured entries oldest-first over a valid/ready port. Sits beside philosophy_v_core, fed by its controller state, IF PC, instruction memory read data and a selectable register-file probe.

---
 rtl/philv_trace_buffer.sv | 216 +++++++++++++++++++++
 tb/tb_philv_trace_buffer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/philv_trace_buffer.sv
// philv_trace_buffer: per-cycle execution tracer for the Philosophy V core.
// Captures {cycle, controller state, PC, instruction, probe} snapshots into a
// circular on-chip buffer over a programmable window, optionally around a PC
// trigger, and streams them back oldest-first.
//
// Read port handshake: rd_data is meaningful only while rd_valid=1 and stays
// stable until the cycle in which rd_valid && rd_ready are both high; that
// cycle transfers one entry and the next entry (if any) appears after the edge.
module philv_trace_buffer #(
  parameter int XLEN      = 32,
  parameter int STATE_W   = 4,
  parameter int DEPTH     = 16,
  parameter int CYC_W     = 16,
  parameter int POST_TRIG = 4
) (
  input  logic                              clk,
  input  logic                              rstb,
  input  logic                              start,
  input  logic                              abort,
  input  logic                              mode,
  input  logic [CYC_W-1:0]                  run_cycles,
  input  logic [XLEN-1:0]                   trig_pc,
  input  logic                              sample_en,
  input  logic [STATE_W-1:0]                core_state,
  input  logic [XLEN-1:0]                   core_pc,
  input  logic [XLEN-1:0]                   core_instr,
  input  logic [XLEN-1:0]                   core_probe,
  output logic                              busy,
  output logic                              triggered,
  output logic                              done,
  output logic                              full,
  output logic [$clog2(DEPTH):0]            entry_count,
  output logic                              rd_valid,
  input  logic                              rd_ready,
  output logic [CYC_W+STATE_W+3*XLEN-1:0]   rd_data
);

  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = AW + 1;
  localparam int PW      = AW + 1;
  localparam int ENTRY_W = CYC_W + STATE_W + 3 * XLEN;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_POST    = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [CYC_W-1:0]   run_q, run_d;
  logic [XLEN-1:0]    trig_q, trig_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               wrapped_q, wrapped_d;
  logic [PW-1:0]      post_cnt_q, post_cnt_d;
  logic               triggered_q, triggered_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               full_q, full_d;

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic               capturing;
  logic               wr_en;
  logic               last_cyc;
  logic               trig_hit;
  logic [CW-1:0]      count_inc;
  logic               rd_fire;

  assign capturing = (state_q == ST_CAPTURE) || (state_q == ST_POST);
  assign wr_en     = capturing && sample_en;
  assign last_cyc  = (cyc_q == (run_q - 1'b1));
  assign trig_hit  = (state_q == ST_CAPTURE) && mode_q && sample_en && (core_pc == trig_q);
  assign count_inc = (count_q == CW'(DEPTH)) ? count_q : (count_q + 1'b1);
  assign rd_valid  = done_q && (count_q != '0);
  assign rd_fire   = rd_valid && rd_ready;

  // Next-state and datapath control for capture, trigger and readout.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    run_d       = run_q;
    trig_d      = trig_q;
    cyc_d       = cyc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    wrapped_d   = wrapped_q;
    post_cnt_d  = post_cnt_q;
    triggered_d = triggered_q;

    if (start && ((state_q == ST_IDLE) || (state_q == ST_DONE))) begin
      // New capture: latch configuration and forget the previous buffer.
      mode_d      = mode;
      run_d       = run_cycles;
      trig_d      = trig_pc;
      cyc_d       = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      wrapped_d   = 1'b0;
      post_cnt_d  = '0;
      triggered_d = 1'b0;
      state_d     = (run_cycles == '0) ? ST_DONE : ST_CAPTURE;
    end else if (capturing) begin
      cyc_d = (&cyc_q) ? cyc_q : (cyc_q + 1'b1);

      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        count_d  = count_inc;
        if (wr_ptr_q == AW'(DEPTH - 1)) begin
          wrapped_d = 1'b1;
        end
      end

      if (state_q == ST_CAPTURE) begin
        if (!mode_q) begin
          // Window mode stops rather than overwrite once the buffer fills.
          if ((wr_en && (count_inc == CW'(DEPTH))) || last_cyc) begin
            state_d = ST_DONE;
          end
        end else if (trig_hit) begin
          // Trigger takes priority over a coincident timeout.
          triggered_d = 1'b1;
          post_cnt_d  = '0;
          state_d     = (POST_TRIG == 0) ? ST_DONE : ST_POST;
        end else if (last_cyc) begin
          state_d = ST_DONE;
        end
      end else begin
        // Post-trigger phase counts sampled entries only; no timeout here.
        if (wr_en) begin
          post_cnt_d = post_cnt_q + 1'b1;
          if ((post_cnt_q + 1'b1) == PW'(POST_TRIG)) begin
            state_d = ST_DONE;
          end
        end
      end

      if (abort) begin
        state_d = ST_DONE;
      end

      // Readout starts at the oldest entry: slot 0 unless the ring wrapped.
      if (state_d == ST_DONE) begin
        rd_ptr_d = wrapped_d ? wr_ptr_d : '0;
      end
    end else if (state_q == ST_DONE) begin
      if (rd_fire) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        count_d  = count_q - 1'b1;
      end
    end
  end

  // Registered status outputs follow the next state and count.
  always_comb begin
    busy_d = (state_d == ST_CAPTURE) || (state_d == ST_POST);
    done_d = (state_d == ST_DONE);
    full_d = (count_d == CW'(DEPTH));
  end

  // Control and status registers.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      state_q     <= ST_IDLE;
      mode_q      <= 1'b0;
      run_q       <= '0;
      trig_q      <= '0;
      cyc_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wrapped_q   <= 1'b0;
      post_cnt_q  <= '0;
      triggered_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      run_q       <= run_d;
      trig_q      <= trig_d;
      cyc_q       <= cyc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wrapped_q   <= wrapped_d;
      post_cnt_q  <= post_cnt_d;
      triggered_q <= triggered_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      full_q      <= full_d;
    end
  end

  // Trace storage; contents are don't-care after reset so no reset here.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {cyc_q, core_state, core_pc, core_instr, core_probe};
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign full        = full_q;
  assign triggered   = triggered_q;
  assign entry_count = count_q;
  assign rd_data     = rd_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_philv_trace_buffer.sv
// Testbench for philv_trace_buffer: directed scenarios plus randomized
// captures, checked against a queue-based model of the trace contents.
module tb_philv_trace_buffer;

  localparam int XLEN      = 32;
  localparam int STATE_W   = 4;
  localparam int DEPTH     = 16;
  localparam int CYC_W     = 16;
  localparam int POST_TRIG = 4;
  localparam int CW        = $clog2(DEPTH) + 1;
  localparam int EW        = CYC_W + STATE_W + 3 * XLEN;

  logic               clk;
  logic               rstb;
  logic               start;
  logic               abort;
  logic               mode;
  logic [CYC_W-1:0]   run_cycles;
  logic [XLEN-1:0]    trig_pc;
  logic               sample_en;
  logic [STATE_W-1:0] core_state;
  logic [XLEN-1:0]    core_pc;
  logic [XLEN-1:0]    core_instr;
  logic [XLEN-1:0]    core_probe;
  logic               busy;
  logic               triggered;
  logic               done;
  logic               full;
  logic [CW-1:0]      entry_count;
  logic               rd_valid;
  logic               rd_ready;
  logic [EW-1:0]      rd_data;

  philv_trace_buffer #(
    .XLEN(XLEN), .STATE_W(STATE_W), .DEPTH(DEPTH), .CYC_W(CYC_W), .POST_TRIG(POST_TRIG)
  ) dut (
    .clk(clk), .rstb(rstb), .start(start), .abort(abort), .mode(mode),
    .run_cycles(run_cycles), .trig_pc(trig_pc), .sample_en(sample_en),
    .core_state(core_state), .core_pc(core_pc), .core_instr(core_instr),
    .core_probe(core_probe), .busy(busy), .triggered(triggered), .done(done),
    .full(full), .entry_count(entry_count), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_data(rd_data)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Run one capture while modelling which samples the trace should retain.
  task automatic capture(input bit m, input int run, input logic [XLEN-1:0] tpc,
                         input bit pc_lin, input int sample_pct, input int abort_at);
    bit fin;
    bit trig;
    bit s;
    int post_left;
    int c;
    logic [XLEN-1:0]    pc;
    logic [STATE_W-1:0] st;
    logic [XLEN-1:0]    ins;
    logic [XLEN-1:0]    prb;
    @(negedge clk);
    start = 1'b1; mode = m; run_cycles = run[CYC_W-1:0]; trig_pc = tpc;
    rd_ready = 1'b0; sample_en = 1'b0; abort = 1'b0;
    exp_q.delete();
    trig = 1'b0;
    post_left = 0;
    fin = (run == 0);
    @(posedge clk); #1;
    if (fin) check_eq("zero_done", done, 1);
    else     check_eq("start_busy", busy, 1);
    c = 0;
    while (!fin && c < 3000) begin
      @(negedge clk);
      start = ($urandom_range(0, 15) == 0);
      s   = ($urandom_range(1, 100) <= sample_pct);
      pc  = pc_lin ? 32'(4 * c) : 32'($urandom_range(0, 15) * 4);
      st  = STATE_W'($urandom);
      ins = $urandom;
      prb = $urandom;
      sample_en = s; core_pc = pc; core_state = st; core_instr = ins; core_probe = prb;
      abort = (c == abort_at);
      if (s) begin
        exp_q.push_back({c[CYC_W-1:0], st, pc, ins, prb});
        if (m && exp_q.size() > DEPTH) void'(exp_q.pop_front());
      end
      if (!m) begin
        if (exp_q.size() == DEPTH || c == run - 1) fin = 1'b1;
      end else if (!trig) begin
        if (s && pc == tpc) begin
          trig = 1'b1;
          post_left = POST_TRIG;
          if (post_left == 0) fin = 1'b1;
        end else if (c == run - 1) begin
          fin = 1'b1;
        end
      end else if (s) begin
        post_left--;
        if (post_left == 0) fin = 1'b1;
      end
      if (c == abort_at) fin = 1'b1;
      @(posedge clk); #1;
      if (!fin) check_eq("busy_cap", busy, 1);
      c++;
    end
    check_eq("cap_end", fin, 1);
    @(negedge clk);
    start = 1'b0; abort = 1'b0; sample_en = 1'b0;
    check_eq("done", done, 1);
    check_eq("busy_done", busy, 0);
    check_eq("count", entry_count, exp_q.size());
    check_eq("triggered", triggered, trig);
    check_eq("full", full, exp_q.size() == DEPTH);
    check_eq("rd_valid", rd_valid, exp_q.size() > 0);
  endtask

  // Read up to max_reads entries; starts and ends at a falling edge.
  task automatic drain(input int max_reads, input bit rnd_ready, input int stall_first);
    int reads = 0;
    int guard = 0;
    while (exp_q.size() > 0 && reads < max_reads && guard < 500) begin
      check_eq("rd_valid_rd", rd_valid, 1);
      check_eq("rd_data", rd_data, exp_q[0]);
      check_eq("rd_count", entry_count, exp_q.size());
      check_eq("rd_full", full, exp_q.size() == DEPTH);
      if (guard < stall_first) rd_ready = 1'b0;
      else if (rnd_ready)      rd_ready = ($urandom_range(0, 2) != 0);
      else                     rd_ready = 1'b1;
      @(posedge clk);
      if (rd_ready) begin
        void'(exp_q.pop_front());
        reads++;
      end
      @(negedge clk);
      guard++;
    end
    rd_ready = 1'b0;
    if (exp_q.size() == 0) begin
      check_eq("empty_valid", rd_valid, 0);
      check_eq("empty_count", entry_count, 0);
      check_eq("empty_data", rd_data, 0);
    end
  endtask

  initial begin
    rstb = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0; run_cycles = '0;
    trig_pc = '0; sample_en = 1'b0; core_state = '0; core_pc = '0;
    core_instr = '0; core_probe = '0; rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_trig", triggered, 0);
    check_eq("rst_full", full, 0);
    check_eq("rst_count", entry_count, 0);
    check_eq("rst_valid", rd_valid, 0);
    check_eq("rst_data", rd_data, 0);
    @(negedge clk);
    rstb = 1'b0;

    // Reset in the middle of a window capture.
    @(negedge clk);
    start = 1'b1; mode = 1'b0; run_cycles = 16'd50;
    @(negedge clk);
    start = 1'b0; sample_en = 1'b1;
    repeat (7) @(negedge clk);
    rstb = 1'b1;
    #1;
    check_eq("arst_busy", busy, 0);
    @(negedge clk);
    rstb = 1'b0; sample_en = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_busy", busy, 0);
    check_eq("mid_done", done, 0);
    check_eq("mid_count", entry_count, 0);
    check_eq("mid_valid", rd_valid, 0);

    // Short window, every cycle sampled.
    capture(1'b0, 5, '0, 1'b1, 100, -1);
    check_eq("w5_first", exp_q[0][EW-1 -: CYC_W], 0);
    drain(100, 1'b0, 0);
    // Window longer than the buffer: stops full, consumer stalls first.
    capture(1'b0, 100, '0, 1'b1, 100, -1);
    check_eq("w100_last", exp_q[DEPTH-1][EW-1 -: CYC_W], 15);
    drain(100, 1'b0, 3);
    // Trigger with post-trigger capture.
    capture(1'b1, 100, 32'h40, 1'b1, 100, -1);
    check_eq("trig_oldest_pc", exp_q[0][3*XLEN-1 -: XLEN], 32'h14);
    drain(100, 1'b1, 0);
    // Trigger never reached: timeout.
    capture(1'b1, 20, 32'hFFC, 1'b1, 100, -1);
    drain(100, 1'b0, 0);
    // Zero-length window.
    capture(1'b0, 0, '0, 1'b1, 100, -1);
    drain(100, 1'b0, 0);
    // Abort at cycle 3.
    capture(1'b0, 50, '0, 1'b1, 100, 3);
    drain(100, 1'b0, 0);

    // Randomized captures; partial drains exercise restart from DONE.
    for (int i = 0; i < 30; i++) begin
      capture(1'($urandom_range(0, 1)), int'($urandom_range(0, 40)),
              32'($urandom_range(0, 15) * 4), 1'($urandom_range(0, 1)),
              int'($urandom_range(50, 100)),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1);
      drain(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : 100, 1'b1,
            int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
